// File: rtl/hilo_pipe_pkg.sv
// Shared HI/LO pipeline types and constants: data width, write enables,
// the in-flight slot record and the per-slot update operation.
package hilo_pipe_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] ZeroWord     = '0;
  localparam logic              WriteEnable  = 1'b1;
  localparam logic              WriteDisable = 1'b0;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_slot_t;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_op_e;

endpackage

// File: rtl/hilo_slot_reg.sv
// One in-flight HI/LO slot: load, hold or clear each edge; reset invalidates.
// Clearing drops only the valid bit; data fields are don't-care once invalid.
module hilo_slot_reg
  import hilo_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  slot_op_e   i_op,
  input  hilo_slot_t i_d,
  output hilo_slot_t o_q
);

  hilo_slot_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q.valid <= WriteDisable;
      r_q.hi    <= ZeroWord;
      r_q.lo    <= ZeroWord;
    end else begin
      case (i_op)
        SLOT_LOAD:  r_q       <= i_d;
        SLOT_CLEAR: r_q.valid <= WriteDisable;
        default:    r_q       <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hilo_pipe.sv
// HI/LO write pipeline: EX -> M -> W -> architectural HI/LO.
// Build option HILO_FWD_EN: forward in-flight M/W values to readers instead of
// raising a hazard stall request.
module hilo_pipe
  import hilo_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_whilo_i,
  input  logic [DATA_W-1:0] ex_hi_i,
  input  logic [DATA_W-1:0] ex_lo_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              rd_req_i,
  output logic [DATA_W-1:0] rd_hi_o,
  output logic [DATA_W-1:0] rd_lo_o,
  output logic              hazard_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  slot_op_e          w_op;
  hilo_slot_t        w_ex_slot;
  hilo_slot_t        w_m_q;
  hilo_slot_t        w_w_q;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // Flush beats stall; reset is applied inside each slot ahead of both.
  always_comb begin
    w_op = SLOT_LOAD;
    if (flush_i)      w_op = SLOT_CLEAR;
    else if (stall_i) w_op = SLOT_HOLD;
  end

  always_comb begin
    w_ex_slot.valid = ex_whilo_i;
    w_ex_slot.hi    = ex_hi_i;
    w_ex_slot.lo    = ex_lo_i;
  end

  hilo_slot_reg u_slot_m (
    .clk  (clk),
    .rst  (rst),
    .i_op (w_op),
    .i_d  (w_ex_slot),
    .o_q  (w_m_q)
  );

  hilo_slot_reg u_slot_w (
    .clk  (clk),
    .rst  (rst),
    .i_op (w_op),
    .i_d  (w_m_q),
    .o_q  (w_w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= ZeroWord;
      r_lo <= ZeroWord;
    end else if (!flush_i && !stall_i && (w_w_q.valid == WriteEnable)) begin
      r_hi <= w_w_q.hi;
      r_lo <= w_w_q.lo;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

`ifdef HILO_FWD_EN
  // Only registered slots feed readers, so ex_* never reaches rd_* combinationally.
  always_comb begin
    rd_hi_o = r_hi;
    rd_lo_o = r_lo;
    if (w_m_q.valid == WriteEnable) begin
      rd_hi_o = w_m_q.hi;
      rd_lo_o = w_m_q.lo;
    end else if (w_w_q.valid == WriteEnable) begin
      rd_hi_o = w_w_q.hi;
      rd_lo_o = w_w_q.lo;
    end
  end

  assign hazard_o = 1'b0;
`else
  assign rd_hi_o  = r_hi;
  assign rd_lo_o  = r_lo;
  assign hazard_o = rd_req_i & (w_m_q.valid | w_w_q.valid);
`endif

endmodule

// File: doc/hilo_pipe.md
HILO_PIPE -- requirements
Module: hilo_pipe

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have port ex_whilo_i  in  1  EX-stage HI/LO write enable from the multiply unit.
REQ-004 SHALL have port ex_hi_i  in  32  EX-stage HI result.
REQ-005 SHALL have port ex_lo_i  in  32  EX-stage LO result.
REQ-006 SHALL have port stall_i  in  1  pipeline stall; freezes all slots.
REQ-007 SHALL have port flush_i  in  1  exception flush; kills all in-flight writes.
REQ-008 SHALL have port rd_req_i  in  1  the current EX instruction reads HI/LO (mfhi/mflo).
REQ-009 SHALL have port rd_hi_o  out  32  HI value supplied to EX readers.
REQ-010 SHALL have port rd_lo_o  out  32  LO value supplied to EX readers.
REQ-011 SHALL have port hazard_o  out  1  stall request for a pending-HI/LO read.
REQ-012 SHALL have port hi_o  out  32  architectural HI register.
REQ-013 SHALL have port lo_o  out  32  architectural LO register.

Function
REQ-014 SHALL hold two in-flight slots, M and W, each {valid, hi, lo}.
REQ-015 SHALL, on each edge with no stall and no flush, load M from {ex_whilo_i, ex_hi_i, ex_lo_i}, load W from M, and write hi_o/lo_o from W when W.valid.
REQ-016 SHALL give a write presented at EX before edge N: M at N, W at N+1, hi_o/lo_o at N+2.
REQ-017 SHALL, on an edge with stall_i=1 and flush_i=0, hold M, W, hi_o and lo_o unchanged.
REQ-018 SHALL, on an edge with flush_i=1, clear M.valid and W.valid, leave hi_o/lo_o unchanged, and ignore stall_i (flush wins).
REQ-019 SHALL leave the hi/lo data fields of a slot don't-care when valid=0; only valid gates any use of the slot.
REQ-020 SHALL compute rd_hi_o/rd_lo_o combinationally with priority M.valid > W.valid > architectural registers.
REQ-021 SHALL NOT forward ex_* inputs to rd_* in the same cycle, so no combinational path from ex_* to rd_* exists.
REQ-022 SHALL, on back-to-back writes, expose the youngest write on rd_* and commit both writes to hi_o/lo_o in order.

Reset
REQ-023 SHALL, on an edge with rst=1, clear M.valid and W.valid and set hi_o=lo_o=0x00000000.
REQ-024 SHALL give rst priority over flush_i and stall_i.
REQ-025 SHALL discard any in-flight write when reset is asserted mid-operation.

Configuration
REQ-026 SHALL implement REQ-020 forwarding only when macro HILO_FWD_EN is defined; in that build hazard_o is constant 0.
REQ-027 SHALL, when HILO_FWD_EN is undefined, drive rd_hi_o=hi_o and rd_lo_o=lo_o, and drive hazard_o = rd_req_i & (M.valid | W.valid).

Structure
REQ-028 SHALL take from the shared package: the 32-bit data width, the ZeroWord constant, the WriteEnable/WriteDisable constants, and a hilo_slot_t typedef {valid, hi[31:0], lo[31:0]}.
REQ-029 SHALL implement each slot as sub-module hilo_slot_reg (load, hold, clear, reset), instantiated twice.

Verification
REQ-030 SHALL cover a single write: ex_whilo=1 with hi=0x00000001, lo=0xFFFFFFFE for one cycle -> rd_hi=0x00000001 after edge 1; hi_o=0x00000001 and lo_o=0xFFFFFFFE after edge 3.
REQ-031 SHALL cover back-to-back writes: hi=0xA, then hi=0xB -> rd_hi=0xB after edge 2; hi_o steps 0xA then 0xB on consecutive edges.
REQ-032 SHALL cover a stall: write 0x5 to M, then stall_i=1 for 3 cycles -> M, W, hi_o frozen; hi_o=0x5 two edges after stall release.
REQ-033 SHALL cover a flush: write 0x7, then flush_i=1 at the next edge -> hi_o stays 0, and rd_hi=0 after the flush edge.
REQ-034 SHALL cover reset: rst=1 mid-flight with M and W both valid -> hi_o=lo_o=0 and no later commit occurs.
REQ-035 SHALL cover the HILO_FWD_EN undefined build: rd_req_i=1 while M.valid=1 -> hazard_o=1; hazard_o=0 once W has committed.
